icache: RTL and testbench
=========================

Name: icache

Overview:
- Direct-mapped, read-only instruction cache between the pipeline's IF stage (PC fetch port) and the memory controller's instruction port.
- Returns hits combinationally in the same cycle.
- On a miss, issues a single-word fill request to memory and holds `ihit` low until the fill completes. The pipeline stalls the PC on `!ihit`.
- Keeps hit and miss counters for performance reporting at halt.

Parameters:
- SETS, 16, number of one-word frames; must be a power of 2; IDX_W = log2(SETS).
- PC_INIT, 0, reserved; unused by logic; kept for parity with the fetch stage.

Ports:
- CLK  input  1  system clock, rising edge
- nRST  input  1  asynchronous active-low reset
- imemREN  input  1  fetch request from datapath
- imemaddr  input  32  fetch byte address; word aligned, [1:0] ignored
- ihit  output  1  hit: `imemload` valid this cycle
- imemload  output  32  instruction word returned to IF/ID
- iwait  input  1  memory controller busy; 0 = `iload` valid this cycle
- iload  input  32  fill data from memory
- iREN  output  1  fill request to memory
- iaddr  output  32  fill word address
- hit_cnt  output  32  cycles in which `ihit` was asserted
- miss_cnt  output  32  number of misses started

Behaviour:
- Address split:
  - tag = `imemaddr[31:IDX_W+2]`
  - index = `imemaddr[IDX_W+1:2]`
  - byte offset `[1:0]` ignored.
- Storage per frame: valid bit, tag, 32-bit data. All valid bits, state, counters and the latched miss address are cleared by `nRST` asynchronously.
- Reset values:
  - `ihit` = 0, `imemload` = 0, `iREN` = 0, `iaddr` = 0, `hit_cnt` = 0, `miss_cnt` = 0.
  - State = IDLE.
  - Outputs hold these values while `nRST` = 0.
- State IDLE:
  - Hit when `imemREN` & valid[index] & tag match.
  - On a hit, `ihit` = 1 and `imemload` = data[index] combinationally in the same cycle. `hit_cnt` increments at the clock edge.
  - Miss when `imemREN` & !hit. `ihit` = 0 and `imemload` = 0.
  - On a miss, the word-aligned address `{imemaddr[31:2], 2'b00}` is latched, `miss_cnt` increments, and the block moves to MISS at the next edge.
  - `imemREN` = 0: `ihit` = 0, `iREN` = 0, no state change.
- State MISS:
  - `iREN` = 1 and `iaddr` = latched address, both held stable for the whole state.
  - `ihit` = 0 regardless of `imemaddr` (no hit-under-miss).
  - When `iwait` = 0 at an edge: write valid = 1, tag and `iload` into the latched frame, then return to IDLE. `iREN` drops the next cycle.
  - Minimum miss penalty: the fill completes at the earliest one edge after entering MISS. The requested word then hits in IDLE the cycle after the fill. There is no same-cycle fill forwarding.
  - `iwait` = 1: remain in MISS, with no limit.
- Boundary cases:
  - **`imemaddr` or `imemREN` changes during MISS** (for example a squash): the fill still completes into the latched frame, then a fresh lookup happens in IDLE. The cache is never left in a partial state.
  - **Conflict miss**: a same-index, different-tag fill overwrites the frame. The old line is lost (no write-back; read-only).
  - **Reset asserted mid-miss**: `iREN` drops immediately. The partially serviced fill is discarded and no frame is written.
  - **Counters**: wrap modulo 2^32 with no saturation.
  - **Simultaneous requests**: none are possible, since only one fill is ever outstanding.
- Timing: the `ihit` path is combinational (tag compare only). The fill write is registered.

Test Plan:
- Cold miss: reset, then `imemREN` = 1, `imemaddr` = 0x00000040, memory returns `iload` = 0x3C010001 with `iwait` = 1 for 2 cycles then 0.
  - Required: `iREN` = 1 and `iaddr` = 0x40 for 3 cycles.
  - Required: `ihit` = 1 and `imemload` = 0x3C010001 on the cycle after the fill.
  - Required: `miss_cnt` = 1.
- Repeat hit: after the cold miss above, hold address 0x40 for 5 cycles.
  - Required: `ihit` = 1 every cycle, `iREN` = 0, `hit_cnt` = 5.
- Conflict eviction: fill 0x00000004, then fetch 0x00000044 (same index 1 with SETS = 16, different tag), then fetch 0x04 again.
  - Required: three misses, `miss_cnt` = 3.
  - Required: `imemload` matches memory for each address in turn.
- Address change mid-miss: miss on 0x80, then switch `imemaddr` to 0x100 while `iwait` = 1.
  - Required: `iaddr` stays 0x80 until the fill and frame 0 gets tag(0x80).
  - Required: 0x100 then starts a new miss with `iaddr` = 0x100.
- Reset mid-miss: assert `nRST` = 0 during MISS with `iwait` = 1.
  - Required: `iREN` = 0 immediately and counters = 0.
  - Required: after release, a fetch of the same address misses again (valid cleared).
- `imemREN` = 0 with a valid line present.
  - Required: `ihit` = 0 and no counter change.

Source files
------------

// File: rtl/icache.sv
// Direct-mapped, read-only, one-word-per-frame instruction cache.
// Hits return combinationally. A miss issues one blocking fill to memory.
module icache #(
    parameter int unsigned SETS    = 16,
    parameter logic [31:0] PC_INIT = '0
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    input  logic        iwait,
    input  logic [31:0] iload,
    output logic        iREN,
    output logic [31:0] iaddr,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
);
    localparam int unsigned IDX_W = $clog2(SETS);
    localparam int unsigned TAG_W = 30 - IDX_W;

    typedef enum logic {
        IDLE,
        MISS
    } state_e;

    state_e           state_q, state_d;
    logic [SETS-1:0]  valid_q, valid_d;
    logic [TAG_W-1:0] tag_q  [SETS];
    logic [TAG_W-1:0] tag_d  [SETS];
    logic [31:0]      data_q [SETS];
    logic [31:0]      data_d [SETS];
    logic [31:0]      miss_addr_q, miss_addr_d;
    logic [31:0]      hit_cnt_q, hit_cnt_d;
    logic [31:0]      miss_cnt_q, miss_cnt_d;

    logic [IDX_W-1:0] req_idx, fill_idx;
    logic [TAG_W-1:0] req_tag, fill_tag;
    logic             hit;
    logic             unused_bits;

    assign req_idx  = imemaddr[IDX_W+1:2];
    assign req_tag  = imemaddr[31:IDX_W+2];
    assign fill_idx = miss_addr_q[IDX_W+1:2];
    assign fill_tag = miss_addr_q[31:IDX_W+2];

    // No hit-under-miss: lookups are only honoured while idle.
    assign hit = (state_q == IDLE) && imemREN && valid_q[req_idx]
                 && (tag_q[req_idx] == req_tag);

    assign ihit        = hit;
    assign imemload    = hit ? data_q[req_idx] : '0;
    assign iREN        = (state_q == MISS);
    assign iaddr       = miss_addr_q;
    assign hit_cnt     = hit_cnt_q;
    assign miss_cnt    = miss_cnt_q;
    assign unused_bits = ^{PC_INIT, imemaddr[1:0], miss_addr_q[1:0]};

    always_comb begin
        state_d     = state_q;
        valid_d     = valid_q;
        tag_d       = tag_q;
        data_d      = data_q;
        miss_addr_d = miss_addr_q;
        hit_cnt_d   = hit_cnt_q;
        miss_cnt_d  = miss_cnt_q;

        case (state_q)
            IDLE: begin
                if (imemREN && !hit) begin
                    miss_addr_d = {imemaddr[31:2], 2'b00};
                    miss_cnt_d  = miss_cnt_q + 32'd1;
                    state_d     = MISS;
                end
            end
            MISS: begin
                // Fill targets the latched frame, whatever the pipeline now requests.
                if (!iwait) begin
                    valid_d[fill_idx] = 1'b1;
                    tag_d[fill_idx]   = fill_tag;
                    data_d[fill_idx]  = iload;
                    state_d           = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (hit) begin
            hit_cnt_d = hit_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q     <= IDLE;
            valid_q     <= '0;
            tag_q       <= '{default: '0};
            data_q      <= '{default: '0};
            miss_addr_q <= '0;
            hit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            tag_q       <= tag_d;
            data_q      <= data_d;
            miss_addr_q <= miss_addr_d;
            hit_cnt_q   <= hit_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
        end
    end
endmodule

// File: tb/tb_icache.sv
// Scoreboard bench for icache: expected words queued per fetch, checked on each ihit.
module tb_icache;
    logic        CLK;
    logic        nRST;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        iwait;
    logic [31:0] iload;
    logic        iREN;
    logic [31:0] iaddr;
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;

    icache #(.SETS(16), .PC_INIT(32'h0)) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .imemREN  (imemREN),
        .imemaddr (imemaddr),
        .ihit     (ihit),
        .imemload (imemload),
        .iwait    (iwait),
        .iload    (iload),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .hit_cnt  (hit_cnt),
        .miss_cnt (miss_cnt)
    );

    int          total;
    int          bad;
    int          wait_cfg;
    int          wcnt;
    int          exp_hit;
    int          exp_miss;
    logic [31:0] sb_q[$];

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a[31:2] == 30'h10) return 32'h3C010001;
        return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Memory side: holds iwait high for wait_cfg cycles of each request.
    always @(negedge CLK) begin
        if (iREN) begin
            if (wcnt < wait_cfg) begin
                iwait = 1'b1;
                wcnt++;
            end else begin
                iwait = 1'b0;
            end
            iload = mem_word(iaddr);
        end else begin
            iwait = 1'b1;
            wcnt  = 0;
            iload = '0;
        end
    end

    // Scoreboard pop on every hit cycle.
    always @(negedge CLK) begin
        if (nRST && ihit) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_hit", imemaddr, 32'hFFFF_FFFF);
            end else begin
                chk("imemload", imemload, sb_q.pop_front());
            end
        end
    end

    // Called at the negedge of the idle miss cycle for address a.
    task automatic service(input logic [31:0] a, input int waits);
        int n;
        chk("miss_nohit", {31'd0, ihit}, 32'd0);
        @(negedge CLK);
        n = 0;
        while (iREN && n < 64) begin
            chk("fill_iaddr", iaddr, {a[31:2], 2'b00});
            chk("fill_nohit", {31'd0, ihit}, 32'd0);
            n++;
            @(negedge CLK);
        end
        chk("fill_cycles", n, waits + 1);
    endtask

    task automatic fetch(input logic [31:0] a, input int waits, input bit want_miss);
        @(posedge CLK); #1;
        wait_cfg = waits;
        imemREN  = 1'b1;
        imemaddr = a;
        sb_q.push_back(mem_word(a));
        @(negedge CLK);
        if (want_miss) begin
            exp_miss++;
            service(a, waits);
        end
        chk("ihit", {31'd0, ihit}, 32'd1);
        chk("hit_no_iren", {31'd0, iREN}, 32'd0);
        exp_hit++;
    endtask

    task automatic check_counters(input string tag);
        @(posedge CLK); #1;
        imemREN = 1'b0;
        @(negedge CLK);
        chk({tag, "_hits"}, hit_cnt, exp_hit);
        chk({tag, "_misses"}, miss_cnt, exp_miss);
    endtask

    // Miss on a, then move the request to b (or drop it) while the fill is pending.
    task automatic miss_switch(input logic [31:0] a, input logic [31:0] b, input int waits,
                               input logic keep_req);
        int n;
        @(posedge CLK); #1;
        wait_cfg = waits;
        imemREN  = 1'b1;
        imemaddr = a;
        exp_miss++;
        @(negedge CLK);
        chk("mm_nohit", {31'd0, ihit}, 32'd0);
        @(posedge CLK); #1;
        imemaddr = b;
        imemREN  = keep_req;
        @(negedge CLK);
        n = 0;
        while (iREN && n < 64) begin
            chk("mm_iaddr", iaddr, {a[31:2], 2'b00});
            chk("mm_nohit_miss", {31'd0, ihit}, 32'd0);
            n++;
            @(negedge CLK);
        end
        chk("mm_fill_cycles", n, waits + 1);
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        wait_cfg = 0;
        wcnt     = 0;
        exp_hit  = 0;
        exp_miss = 0;
        iwait    = 1'b1;
        iload    = '0;
        nRST     = 1'b0;
        imemREN  = 1'b0;
        imemaddr = '0;
        repeat (2) @(negedge CLK);
        chk("rst_ihit", {31'd0, ihit}, 32'd0);
        chk("rst_imemload", imemload, 32'd0);
        chk("rst_iren", {31'd0, iREN}, 32'd0);
        chk("rst_iaddr", iaddr, 32'd0);
        chk("rst_hits", hit_cnt, 32'd0);
        chk("rst_misses", miss_cnt, 32'd0);
        nRST = 1'b1;

        // Cold miss with two wait cycles, then four more hits on the same word.
        fetch(32'h40, 2, 1'b1);
        chk("cold_misses", miss_cnt, 32'd1);
        repeat (4) fetch(32'h40, 0, 1'b0);
        check_counters("repeat");
        chk("repeat_hit5", hit_cnt, 32'd5);

        // No request with a valid line present.
        @(posedge CLK); #1;
        imemaddr = 32'h40;
        imemREN  = 1'b0;
        repeat (3) begin
            @(negedge CLK);
            chk("noreq_ihit", {31'd0, ihit}, 32'd0);
            chk("noreq_iren", {31'd0, iREN}, 32'd0);
        end
        check_counters("noreq");

        // Conflict eviction in index 1.
        fetch(32'h04, 1, 1'b1);
        fetch(32'h44, 0, 1'b1);
        fetch(32'h04, 3, 1'b1);
        fetch(32'h04, 0, 1'b0);
        check_counters("conflict");

        // Address change mid-miss: 0x80 fill completes, then 0x100 misses.
        miss_switch(32'h80, 32'h100, 3, 1'b1);
        sb_q.push_back(mem_word(32'h100));
        exp_miss++;
        service(32'h100, 3);
        chk("switch_ihit", {31'd0, ihit}, 32'd1);
        exp_hit++;
        check_counters("switch");

        // Squash mid-miss: fill still lands, so 0x84 hits afterwards.
        miss_switch(32'h84, 32'hC4, 2, 1'b0);
        chk("squash_nohit", {31'd0, ihit}, 32'd0);
        fetch(32'h84, 0, 1'b0);
        check_counters("squash");

        // Reset in the middle of a long miss.
        @(posedge CLK); #1;
        wait_cfg = 100;
        imemREN  = 1'b1;
        imemaddr = 32'h200;
        repeat (2) @(negedge CLK);
        chk("pre_rst_iren", {31'd0, iREN}, 32'd1);
        nRST = 1'b0;
        #1;
        chk("mid_rst_iren", {31'd0, iREN}, 32'd0);
        chk("mid_rst_hits", hit_cnt, 32'd0);
        chk("mid_rst_misses", miss_cnt, 32'd0);
        exp_hit  = 0;
        exp_miss = 0;
        imemREN  = 1'b0;
        @(negedge CLK);
        nRST = 1'b1;
        fetch(32'h200, 1, 1'b1);
        fetch(32'h40, 0, 1'b1);
        fetch(32'h84, 2, 1'b1);
        check_counters("post_rst");

        chk("sb_drain", sb_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got=running exp=finished");
        $fatal(1);
    end
endmodule
